note_track_gen: RTL and testbench

NOTE_TRACK_GEN -- requirements
Module: note_track_gen

---
 rtl/note_track_gen.sv | 192 +++++++++++++++++++
 tb/tb_note_track_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_track_gen.sv
`timescale 1ns/1ps
// note_track_gen: four-lane falling-note track generator for a rhythm game.
// Chart beats are accepted over a valid/ready handshake and spawn NOTE_H-row
// notes at row 0 of the selected lanes. Every STEP_DIV clocks the tracks scroll
// down one row. Synchronized key presses landing while a note overlaps the
// judgment window score a hit; a note whose trailing edge leaves the window
// unhit scores a miss.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, pause       level controls (IDLE -> RUN, RUN <-> PAUSE)
//   note_valid         chart beat offered
//   note_lanes[3:0]    lanes receiving a note in the offered beat (0 = rest)
//   note_ready         beat accepted on a cycle with note_valid && note_ready
//   key[3:0]           raw asynchronous lane keys, active-high
//   track0..track3     lane bitmaps, bit y = screen row y (row 0 at top)
//   hit_pulse[3:0]     one-cycle per-lane hit strobes
//   miss_pulse[3:0]    one-cycle per-lane miss strobes
//   score[15:0]        saturating accumulated score
//   combo[9:0]         saturating consecutive-hit count
//   fsm_state[1:0]     current state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Handshake: a beat transfers on any rising edge where note_valid and
// note_ready are both high; note_valid may be held, note_lanes must be stable
// while note_valid is high, and note_ready never depends on note_valid.
module note_track_gen #(
  parameter int TRACK_LEN = 480,
  parameter int NOTE_H    = 16,
  parameter int STEP_DIV  = 250000,
  parameter int HIT_LO    = 424,
  parameter int HIT_HI    = 455
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 note_valid,
  input  logic [3:0]           note_lanes,
  output logic                 note_ready,
  input  logic [3:0]           key,
  output logic [TRACK_LEN-1:0] track0,
  output logic [TRACK_LEN-1:0] track1,
  output logic [TRACK_LEN-1:0] track2,
  output logic [TRACK_LEN-1:0] track3,
  output logic [3:0]           hit_pulse,
  output logic [3:0]           miss_pulse,
  output logic [15:0]          score,
  output logic [9:0]           combo,
  output logic [1:0]           fsm_state
);

  localparam int DIV_W   = $clog2(STEP_DIV + 1);
  localparam int SPAWN_W = $clog2(NOTE_H + 1);
  localparam int GAP_W   = $clog2(2 * NOTE_H + 1);
  // A hit wipes the lane from just below the window bottom (one note height
  // up) to the end of the track; rows below that are kept.
  localparam int KEEP_BITS = HIT_LO - NOTE_H + 1;
  localparam logic [TRACK_LEN-1:0] KEEP_MASK =
    {TRACK_LEN{1'b1}} >> (TRACK_LEN - KEEP_BITS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 run;
  logic [DIV_W-1:0]     div_cnt;
  logic                 step_raw, step_pend, step_req, do_step;
  logic [GAP_W-1:0]     gap_cnt;
  logic [SPAWN_W-1:0]   spawn_cnt [4];
  logic [TRACK_LEN-1:0] trk [4];
  logic [3:0]           sync1, sync2, key_prev, rise_q;
  logic [3:0]           hit, miss;
  logic                 hit_any, accept;
  logic [9:0]           combo_n;
  logic [15:0]          score_n;
  logic [16:0]          sum;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    run        = 1'b0;
    note_ready = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        run        = 1'b1;
        note_ready = (gap_cnt == '0);
        if (pause) state_d = PAUSE;
      end
      PAUSE: if (!pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  // ---------------- step / judgment qualifiers ----------------
  assign step_raw = run && (div_cnt == DIV_W'(STEP_DIV - 1));
  assign step_req = step_raw || step_pend;
  assign accept   = note_valid && note_ready;

  always_comb begin
    hit  = '0;
    miss = '0;
    for (int l = 0; l < 4; l++) begin
      hit[l]  = run && rise_q[l] && (|trk[l][HIT_HI:HIT_LO]);
      miss[l] = trk[l][HIT_HI] && !trk[l][HIT_HI-1];
    end
  end

  assign hit_any = |hit;
  // A hit owns the tracks this cycle; any step due now waits one cycle.
  assign do_step = run && step_req && !hit_any;

  // Lanes are credited in index order so each later lane sees the combo
  // already bumped by the earlier ones.
  always_comb begin
    combo_n = combo;
    score_n = score;
    sum     = '0;
    for (int l = 0; l < 4; l++) begin
      if (hit[l]) begin
        sum     = {1'b0, score_n} + ((combo_n >= 10'd10) ? 17'd2 : 17'd1);
        score_n = sum[16] ? 16'hFFFF : sum[15:0];
        if (combo_n != 10'd1023) combo_n = combo_n + 10'd1;
      end
    end
    if (do_step && (|miss)) combo_n = '0;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      step_pend  <= 1'b0;
      gap_cnt    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      key_prev   <= '0;
      rise_q     <= '0;
      hit_pulse  <= '0;
      miss_pulse <= '0;
      combo      <= '0;
      score      <= '0;
      for (int l = 0; l < 4; l++) begin
        spawn_cnt[l] <= '0;
        trk[l]       <= '0;
      end
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      key_prev <= sync2;
      rise_q   <= sync2 & ~key_prev;

      hit_pulse  <= hit;
      miss_pulse <= do_step ? miss : 4'b0000;
      combo      <= combo_n;
      score      <= score_n;

      // Divider and pending step both hold outside RUN.
      if (run) begin
        div_cnt   <= step_raw ? '0 : div_cnt + DIV_W'(1);
        step_pend <= step_req && hit_any;
      end

      if (accept)                        gap_cnt <= GAP_W'(2 * NOTE_H);
      else if (do_step && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);

      for (int l = 0; l < 4; l++) begin
        if (accept && note_lanes[l])
          spawn_cnt[l] <= SPAWN_W'(NOTE_H);
        else if (do_step && spawn_cnt[l] != '0)
          spawn_cnt[l] <= spawn_cnt[l] - SPAWN_W'(1);

        if (hit[l])
          trk[l] <= trk[l] & KEEP_MASK;
        else if (do_step)
          trk[l] <= {trk[l][TRACK_LEN-2:0], (spawn_cnt[l] != '0)};
      end
    end
  end

  assign track0 = trk[0];
  assign track1 = trk[1];
  assign track2 = trk[2];
  assign track3 = trk[3];

endmodule

// File: tb/tb_note_track_gen.sv
`timescale 1ns/1ps
// Directed bench for note_track_gen with a short divider and 4-row notes.
// Step k of a play session lands on clock edge base + 4*k, counted from the
// edge after start is raised; all expected rows are derived from that.
module tb_note_track_gen;
  localparam int TL = 480;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, pause = 1'b0, note_valid = 1'b0;
  logic [3:0]    note_lanes = '0, key = '0;
  logic          note_ready;
  logic [TL-1:0] track0, track1, track2, track3;
  logic [3:0]    hit_pulse, miss_pulse;
  logic [15:0]   score;
  logic [9:0]    combo;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int now  = 0;
  int base = 1;
  logic [TL-1:0] exp_t;

  note_track_gen #(
    .TRACK_LEN(TL), .NOTE_H(4), .STEP_DIV(4), .HIT_LO(424), .HIT_HI(455)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .note_valid(note_valid), .note_lanes(note_lanes), .note_ready(note_ready),
    .key(key), .track0(track0), .track1(track1), .track2(track2),
    .track3(track3), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .combo(combo), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
      now += n;
    end
  endtask

  function automatic int step_edge(input int k);
    return base + 4 * k;
  endfunction

  task automatic at(input int e);
    tick(e - now);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; pause = 1'b0; note_valid = 1'b0;
    note_lanes = '0; key = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // Leaves the bench just after step 1.
  task automatic begin_play(input logic [3:0] lanes, input logic offer, input logic keep);
    now = 0; base = 1;
    start = 1'b1; note_valid = offer; note_lanes = lanes;
    tick(1);
    start = 1'b0;
    tick(1);
    if (!keep) note_valid = 1'b0;
    at(step_edge(1));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; note_valid = 1'b1; note_lanes = 4'b1111;
    tick(2);
    checks++;
    if ({track0, track1, track2, track3} !== '0) begin
      errors++; $display("FAIL reset_tracks: got nonzero want 0");
    end
    checks++;
    if ({score, combo, hit_pulse, miss_pulse, note_ready, fsm_state} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h %h %h %h %b %0d want all 0",
                         score, combo, hit_pulse, miss_pulse, note_ready, fsm_state);
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if (note_ready !== 1'b0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL idle_ready: got ready %b state %0d want 0 0", note_ready, fsm_state);
    end
    note_valid = 1'b0;
  endtask

  task automatic test_accept();
    do_reset();
    now = 0; base = 1;
    start = 1'b1; note_valid = 1'b1; note_lanes = 4'b0001;
    tick(1);
    start = 1'b0;
    checks++;
    if (note_ready !== 1'b1 || fsm_state !== 2'd1) begin
      errors++; $display("FAIL run_ready: got ready %b state %0d want 1 1", note_ready, fsm_state);
    end
    tick(1);
    note_valid = 1'b0;
    checks++;
    if (note_ready !== 1'b0) begin
      errors++; $display("FAIL accept_ready: got %b want 0", note_ready);
    end
    at(step_edge(1));
    exp_t = TL'(1);
    checks++;
    if (track0 !== exp_t) begin
      errors++; $display("FAIL step1_track0: got %h want %h", track0, exp_t);
    end
    at(step_edge(4));
    exp_t = TL'(4'hF);
    checks++;
    if (track0 !== exp_t) begin
      errors++; $display("FAIL step4_track0: got %h want %h", track0, exp_t);
    end
    at(step_edge(7));
    checks++;
    if (note_ready !== 1'b0) begin
      errors++; $display("FAIL gap_step7: got %b want 0", note_ready);
    end
    at(step_edge(8));
    exp_t = TL'(8'hF0);
    checks++;
    if (note_ready !== 1'b1 || track0 !== exp_t) begin
      errors++; $display("FAIL gap_step8: got ready %b track %h want 1 %h", note_ready, track0, exp_t);
    end
  endtask

  // Continues the note from test_accept.
  task automatic test_miss();
    at(step_edge(459));
    exp_t = TL'(4'hF) << 455;
    checks++;
    if (miss_pulse !== 4'b0000 || track0 !== exp_t) begin
      errors++; $display("FAIL pre_miss: got miss %b track %h want 0 %h", miss_pulse, track0, exp_t);
    end
    at(step_edge(460));
    checks++;
    if (miss_pulse !== 4'b0001 || combo !== 10'd0 || score !== 16'd0) begin
      errors++; $display("FAIL miss: got miss %b combo %0d score %0d want 0001 0 0", miss_pulse, combo, score);
    end
    tick(1);
    checks++;
    if (miss_pulse !== 4'b0000) begin
      errors++; $display("FAIL miss_width: got %b want 0000", miss_pulse);
    end
    at(step_edge(483));
    exp_t = TL'(1) << 479;
    checks++;
    if (track0 !== exp_t) begin
      errors++; $display("FAIL last_row: got %h want %h", track0, exp_t);
    end
    at(step_edge(484));
    checks++;
    if (track0 !== '0) begin
      errors++; $display("FAIL discard: got %h want 0", track0);
    end
  endtask

  task automatic test_hit();
    do_reset();
    begin_play(4'b0001, 1'b1, 1'b0);
    at(step_edge(433) + 1);
    key = 4'b0001;
    at(step_edge(434));
    exp_t = TL'(4'hF) << 430;
    checks++;
    if (hit_pulse !== 4'b0000 || track0 !== exp_t) begin
      errors++; $display("FAIL pre_hit: got hit %b track %h want 0 %h", hit_pulse, track0, exp_t);
    end
    tick(1);
    checks++;
    if (hit_pulse !== 4'b0001 || track0 !== '0 || combo !== 10'd1 || score !== 16'd1) begin
      errors++; $display("FAIL hit: got hit %b combo %0d score %0d track %h want 0001 1 1 0",
                         hit_pulse, combo, score, track0);
    end
    key = 4'b0000;
    tick(1);
    checks++;
    if (hit_pulse !== 4'b0000) begin
      errors++; $display("FAIL hit_width: got %b want 0000", hit_pulse);
    end
  endtask

  // Notes every 8 steps; each is hit at rows 425..428 so the next note
  // (rows 417..420) lies below the cleared region.
  task automatic test_combo();
    int c_exp;
    int s_exp;
    c_exp = 0; s_exp = 0;
    do_reset();
    begin_play(4'b0001, 1'b1, 1'b1);
    for (int n = 0; n < 11; n++) begin
      at(step_edge(428 + 8 * n) + 1);
      key = 4'b0001;
      at(step_edge(429 + 8 * n) + 1);
      s_exp += (c_exp >= 10) ? 2 : 1;
      c_exp += 1;
      checks++;
      if (hit_pulse !== 4'b0001 || combo !== 10'(c_exp) || score !== 16'(s_exp)
          || track0[TL-1:421] !== '0) begin
        errors++; $display("FAIL combo_hit%0d: got hit %b combo %0d score %0d want 0001 %0d %0d",
                           n, hit_pulse, combo, score, c_exp, s_exp);
      end
      key = 4'b0000;
    end
    note_valid = 1'b0;
    at(step_edge(547));
    checks++;
    if (combo !== 10'd11 || score !== 16'd12 || miss_pulse !== 4'b0000) begin
      errors++; $display("FAIL combo_total: got combo %0d score %0d miss %b want 11 12 0000",
                         combo, score, miss_pulse);
    end
    at(step_edge(548));
    checks++;
    if (miss_pulse !== 4'b0001 || combo !== 10'd0 || score !== 16'd12) begin
      errors++; $display("FAIL combo_break: got miss %b combo %0d score %0d want 0001 0 12",
                         miss_pulse, combo, score);
    end
  endtask

  task automatic test_multi_lane();
    do_reset();
    begin_play(4'b0101, 1'b1, 1'b0);
    at(step_edge(433) + 1);
    key = 4'b0101;
    at(step_edge(434) + 1);
    checks++;
    if (hit_pulse !== 4'b0101 || combo !== 10'd2 || score !== 16'd2
        || track0 !== '0 || track2 !== '0) begin
      errors++; $display("FAIL multi_hit: got hit %b combo %0d score %0d want 0101 2 2",
                         hit_pulse, combo, score);
    end
    key = 4'b0000;
  endtask

  task automatic test_pause();
    int bad;
    bad = 0;
    do_reset();
    begin_play(4'b0001, 1'b1, 1'b0);
    at(step_edge(430));
    pause = 1'b1;
    exp_t = TL'(4'hF) << 426;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 3)  key = 4'b0001;
      if (i == 12) key = 4'b0000;
      if (track0 !== exp_t || hit_pulse !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pause_freeze: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (fsm_state !== 2'd2 || score !== 16'd0 || combo !== 10'd0) begin
      errors++; $display("FAIL pause_state: got state %0d score %0d combo %0d want 2 0 0",
                         fsm_state, score, combo);
    end
    pause = 1'b0;
    at(step_edge(430) + 23);
    checks++;
    if (track0 !== exp_t) begin
      errors++; $display("FAIL resume_early: got %h want %h", track0, exp_t);
    end
    at(step_edge(430) + 24);
    exp_t = TL'(4'hF) << 427;
    checks++;
    if (track0 !== exp_t || fsm_state !== 2'd1) begin
      errors++; $display("FAIL resume_phase: got %h state %0d want %h 1", track0, fsm_state, exp_t);
    end
  endtask

  // Hit lands exactly on step 431; lane 1 (not pressed) shows the step timing.
  task automatic test_collide();
    do_reset();
    begin_play(4'b0011, 1'b1, 1'b0);
    at(step_edge(430));
    key = 4'b0001;
    at(step_edge(431));
    exp_t = TL'(4'hF) << 426;
    checks++;
    if (hit_pulse !== 4'b0001 || track0 !== '0 || track1 !== exp_t) begin
      errors++; $display("FAIL collide_hit: got hit %b track1 %h want 0001 %h", hit_pulse, track1, exp_t);
    end
    key = 4'b0000;
    tick(1);
    exp_t = TL'(4'hF) << 427;
    checks++;
    if (track1 !== exp_t || hit_pulse !== 4'b0000) begin
      errors++; $display("FAIL collide_deferred: got %h want %h", track1, exp_t);
    end
    at(step_edge(432));
    exp_t = TL'(4'hF) << 428;
    checks++;
    if (track1 !== exp_t) begin
      errors++; $display("FAIL collide_next: got %h want %h", track1, exp_t);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    begin_play(4'b0001, 1'b1, 1'b0);
    at(step_edge(2));
    exp_t = TL'(2'b11);
    checks++;
    if (track0 !== exp_t) begin
      errors++; $display("FAIL pre_abort: got %h want %h", track0, exp_t);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (track0 !== '0 || fsm_state !== 2'd0 || note_ready !== 1'b0) begin
      errors++; $display("FAIL abort: got track %h state %0d ready %b want 0 0 0", track0, fsm_state, note_ready);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    begin_play(4'b0000, 1'b0, 1'b0);
    at(step_edge(6));
    checks++;
    if (track0 !== '0) begin
      errors++; $display("FAIL spawn_discard: got %h want 0", track0);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_accept();
    test_miss();
    test_hit();
    test_combo();
    test_multi_lane();
    test_pause();
    test_collide();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
